// File: rtl/instruction_assembler_writer_pkg.sv
// Shared definitions for the instruction assembler/writer: format codes,
// MIPS field widths and FSM state encodings.
package instruction_assembler_writer_pkg;

   localparam logic [1:0] FMT_R   = 2'b00;
   localparam logic [1:0] FMT_I   = 2'b01;
   localparam logic [1:0] FMT_J   = 2'b10;
   localparam logic [1:0] FMT_BAD = 2'b11;

   localparam int OP_W    = 6;
   localparam int REG_W   = 5;
   localparam int SHAMT_W = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int TGT_W   = 26;
   localparam int WORD_W  = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/instruction_assembler_writer_packer.sv
// Combinational packer: format code plus decoded MIPS fields -> 32-bit word.
// Fields not used by the selected format are ignored; fmt=11 raises bad_o.
module instruction_assembler_writer_packer
   import instruction_assembler_writer_pkg::*;
(
   input  logic [1:0]          fmt_i,
   input  logic [OP_W-1:0]     opcode_i,
   input  logic [REG_W-1:0]    rs_i,
   input  logic [REG_W-1:0]    rt_i,
   input  logic [REG_W-1:0]    rd_i,
   input  logic [SHAMT_W-1:0]  shamt_i,
   input  logic [FUNCT_W-1:0]  funct_i,
   input  logic [IMM_W-1:0]    imm_i,
   input  logic [TGT_W-1:0]    target_i,
   output logic [WORD_W-1:0]   word_o,
   output logic                bad_o
);

   always_comb begin
      word_o = '0;
      bad_o  = 1'b0;
      case (fmt_i)
         FMT_R:   word_o = {opcode_i, rs_i, rt_i, rd_i, shamt_i, funct_i};
         FMT_I:   word_o = {opcode_i, rs_i, rt_i, imm_i};
         FMT_J:   word_o = {opcode_i, target_i};
         FMT_BAD: bad_o  = 1'b1;
         default: bad_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/instruction_assembler_writer.sv
// Packs decoded MIPS fields into instruction words and writes them to
// consecutive instruction-memory addresses until DEPTH words have been stored.
module instruction_assembler_writer
   import instruction_assembler_writer_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
)
(
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                clear_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [1:0]          fmt_i,
   input  logic [OP_W-1:0]     opcode_i,
   input  logic [REG_W-1:0]    rs_i,
   input  logic [REG_W-1:0]    rt_i,
   input  logic [REG_W-1:0]    rd_i,
   input  logic [SHAMT_W-1:0]  shamt_i,
   input  logic [FUNCT_W-1:0]  funct_i,
   input  logic [IMM_W-1:0]    imm_i,
   input  logic [TGT_W-1:0]    target_i,
   output logic                imem_we_o,
   output logic [ADDR_W-1:0]   imem_addr_o,
   output logic [WORD_W-1:0]   imem_wdata_o,
   output logic [ADDR_W:0]     instr_count_o,
   output logic                full_o,
   output logic                fmt_err_o
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   logic [1:0]        state_q,   state_d;
   logic              we_q,      we_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   word_t             wdata_q,   wdata_d;
   logic [ADDR_W:0]   count_q,   count_d;
   logic              full_q,    full_d;
   logic              fmt_err_q, fmt_err_d;

   word_t             packed_w;
   logic              bad_w;
   logic [ADDR_W:0]   count_inc_w;
   logic [ADDR_W-1:0] wr_addr_w;
   logic              last_pending_w;
   logic              accept_w;
   logic              write_w;

   instruction_assembler_writer_packer u_packer (
      .fmt_i    (fmt_i),
      .opcode_i (opcode_i),
      .rs_i     (rs_i),
      .rt_i     (rt_i),
      .rd_i     (rd_i),
      .shamt_i  (shamt_i),
      .funct_i  (funct_i),
      .imm_i    (imm_i),
      .target_i (target_i),
      .word_o   (packed_w),
      .bad_o    (bad_w)
   );

   // The count trails the write strobe by one edge, so the next free address
   // is the count plus any write currently on the bus.
   assign count_inc_w    = count_q + ONE_C;
   assign wr_addr_w      = count_q[ADDR_W-1:0] + ADDR_W'(we_q);
   assign last_pending_w = we_q && (count_inc_w == DEPTH_C);

   assign in_ready_o = !full_q && !last_pending_w && !clear_i && !reset_i;
   assign accept_w   = in_valid_i && in_ready_o;
   assign write_w    = accept_w && !bad_w;

   always_comb begin
      state_d   = state_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      count_d   = we_q ? count_inc_w : count_q;
      full_d    = 1'b0;
      fmt_err_d = 1'b0;
      if (clear_i) begin
         state_d = ST_IDLE;
         addr_d  = '0;
         wdata_d = '0;
         count_d = '0;
      end else begin
         fmt_err_d = accept_w && bad_w;
         if (write_w) begin
            we_d    = 1'b1;
            addr_d  = wr_addr_w;
            wdata_d = packed_w;
         end
         full_d = (count_d == DEPTH_C);
         case (state_q)
            ST_IDLE:  state_d = write_w ? ST_WRITE : ST_IDLE;
            ST_WRITE: begin
               if (last_pending_w)  state_d = ST_FULL;
               else if (write_w)    state_d = ST_WRITE;
               else                 state_d = ST_IDLE;
            end
            ST_FULL:  state_d = ST_FULL;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= ST_IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         fmt_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         count_q   <= count_d;
         full_q    <= full_d;
         fmt_err_q <= fmt_err_d;
      end
   end

   assign imem_we_o     = we_q;
   assign imem_addr_o   = addr_q;
   assign imem_wdata_o  = wdata_q;
   assign instr_count_o = count_q;
   assign full_o        = full_q;
   assign fmt_err_o     = fmt_err_q;

endmodule
